// File: rtl/imm_encoder.sv
// imm_encoder: packs decoded RV32 fields and a signed immediate into I/S/B words with sequential addresses.
// Define IMM_RANGE_CHECK_EN to reject out-of-range or misaligned immediates.
module imm_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_imm_src,
  input  logic [31:0]       i_imm,
  input  logic [6:0]        i_op,
  input  logic [2:0]        i_funct3,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W+1:0] o_addr,
  output logic              o_full,
  output logic              o_err,
  output logic [7:0]        o_err_cnt
);

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_B   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  fmt_e              fmt;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [31:0]       enc;
  logic              range_bad;
  logic              reject;
  logic              in_hs, out_hs, last_out;

  assign fmt = fmt_e'(i_imm_src);

  always_comb begin
    enc = '0;
    enc[6:0]   = i_op;
    enc[14:12] = i_funct3;
    enc[19:15] = i_rs1;
    unique case (fmt)
      FMT_I: begin
        enc[31:20] = i_imm[11:0];
        enc[11:7]  = i_rd;
      end
      FMT_S: begin
        enc[31:25] = i_imm[11:5];
        enc[24:20] = i_rs2;
        enc[11:7]  = i_imm[4:0];
      end
      FMT_B: begin
        enc[31]    = i_imm[12];
        enc[30:25] = i_imm[10:5];
        enc[24:20] = i_rs2;
        enc[11:8]  = i_imm[4:1];
        enc[7]     = i_imm[11];
      end
      default: enc = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_bad = 1'b0;
    unique case (fmt)
      FMT_I, FMT_S: range_bad = ($signed(i_imm) < -32'sd2048) || ($signed(i_imm) > 32'sd2047);
      FMT_B:        range_bad = ($signed(i_imm) < -32'sd4096) || ($signed(i_imm) > 32'sd4094) || i_imm[0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  // Upper immediate bits are intentionally dropped when range checking is off.
  logic unused_imm_hi;
  assign unused_imm_hi = ^i_imm[31:13];
  assign range_bad     = 1'b0;
`endif

  assign reject   = (fmt == FMT_RSV) || range_bad;
  assign o_ready  = !full_q && (!valid_q || i_ready);
  assign in_hs    = i_valid && o_ready;
  assign out_hs   = valid_q && i_ready;
  assign last_out = out_hs && (idx_q == '1);

  // A request accepted alongside the final window word has nowhere to go and is dropped.
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    idx_d     = idx_q;
    full_d    = full_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (i_clear) begin
      valid_d = 1'b0;
      idx_d   = '0;
      full_d  = 1'b0;
    end else begin
      if (out_hs) begin
        valid_d = 1'b0;
        if (last_out) full_d = 1'b1;
        else          idx_d  = idx_q + ADDR_W'(1);
      end
      if (in_hs) begin
        if (reject) begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
        end else if (!last_out) begin
          valid_d = 1'b1;
          instr_d = enc;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      idx_q     <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      idx_q     <= idx_d;
      full_q    <= full_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_instr   = instr_q;
  assign o_addr    = {idx_q, 2'b00};
  assign o_full    = full_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder with a 4-word window.
module tb_imm_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, clr, iv, ir;
  logic [1:0]    src;
  logic [31:0]   imm;
  logic [6:0]    op;
  logic [2:0]    f3;
  logic [4:0]    rd, rs1, rs2;
  logic          o_ready, o_valid, o_full, o_err;
  logic [31:0]   o_instr;
  logic [AW+1:0] o_addr;
  logic [7:0]    o_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int exp_idx  = 0;

  imm_encoder #(.ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(iv), .o_ready(o_ready),
    .i_imm_src(src), .i_imm(imm), .i_op(op), .i_funct3(f3), .i_rd(rd),
    .i_rs1(rs1), .i_rs2(rs2), .o_valid(o_valid), .i_ready(ir),
    .o_instr(o_instr), .o_addr(o_addr), .o_full(o_full), .o_err(o_err),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] s, input logic [31:0] im, input logic [6:0] o,
                     input logic [2:0] f, input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b);
    src = s; imm = im; op = o; f3 = f; rd = d; rs1 = a; rs2 = b;
    iv  = 1'b1;
  endtask

  task automatic clear_cycle();
    clr = 1'b1; iv = 1'b0;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; iv = 1'b0; ir = 1'b0;
    src = '0; imm = '0; op = '0; f3 = '0; rd = '0; rs1 = '0; rs2 = '0;
    #2;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_instr", o_instr, 0);
    check("rst_addr", 32'(o_addr), 0);
    check("rst_full", 32'(o_full), 0);
    check("rst_err", 32'(o_err), 0);
    check("rst_cnt", 32'(o_err_cnt), 0);
    check("rst_ready", 32'(o_ready), 1);
    step();
    rst = 1'b0;

    // I-type, one-cycle latency
    req(2'b00, -32'sd1, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0);
    step(); iv = 1'b0;
    check("i_valid", 32'(o_valid), 1);
    check("i_instr", o_instr, 32'hFFF00293);
    check("i_addr", 32'(o_addr), 0);
    check("i_err", 32'(o_err), 0);

    // S then B with handshake on the same edge
    clear_cycle();
    req(2'b01, 32'd8, 7'b0100011, 3'b010, 5'd0, 5'd2, 5'd1);
    step();
    check("s_instr", o_instr, 32'h00112423);
    check("s_addr", 32'(o_addr), 0);
    ir = 1'b1;
    req(2'b10, -32'sd4, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2);
    step(); iv = 1'b0;
    check("b_instr", o_instr, 32'hFE208EE3);
    check("b_addr", 32'(o_addr), 4);
    step();
    check("b_drain", 32'(o_valid), 0);

    // Range and reserved-format handling
    clear_cycle(); exp_idx = 0; ir = 1'b1;
    req(2'b00, 32'd2048, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0);
    step(); iv = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    exp_cnt++;
    check("rng_i_valid", 32'(o_valid), 0);
    check("rng_i_err", 32'(o_err), 1);
    check("rng_i_cnt", 32'(o_err_cnt), 32'(exp_cnt));
    check("rng_i_addr", 32'(o_addr), 0);
`else
    check("trunc_i_valid", 32'(o_valid), 1);
    check("trunc_i_instr", o_instr, 32'h80000293);
    check("trunc_i_addr", 32'(o_addr), 0);
    check("trunc_i_err", 32'(o_err), 0);
    exp_idx = 1;
`endif
    step();
    check("err_pulse_end", 32'(o_err), 0);

    req(2'b11, 32'd0, 7'b0010011, 3'b000, 5'd1, 5'd1, 5'd1);
    step(); iv = 1'b0; exp_cnt++;
    check("rsv_err", 32'(o_err), 1);
    check("rsv_cnt", 32'(o_err_cnt), 32'(exp_cnt));
    check("rsv_valid", 32'(o_valid), 0);
    check("rsv_addr", 32'(o_addr), 32'(exp_idx * 4));
    step();
    check("rsv_err_end", 32'(o_err), 0);

    req(2'b10, 32'd6, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2);
    step(); iv = 1'b0;
    check("b6_valid", 32'(o_valid), 1);
    check("b6_instr", o_instr, 32'h00208363);
    check("b6_addr", 32'(o_addr), 32'(exp_idx * 4));
    step(); exp_idx++;

    req(2'b10, 32'd3, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2);
    step(); iv = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    exp_cnt++;
    check("b3_valid", 32'(o_valid), 0);
    check("b3_err", 32'(o_err), 1);
    check("b3_cnt", 32'(o_err_cnt), 32'(exp_cnt));
`else
    check("b3_valid", 32'(o_valid), 1);
    check("b3_instr", o_instr, 32'h00208163);
    check("b3_addr", 32'(o_addr), 32'(exp_idx * 4));
`endif
    step();

    // Backpressure
    clear_cycle(); ir = 1'b0;
    req(2'b00, 32'd1, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0);
    step();
    imm = 32'd2;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(o_ready), 0);
      check("bp_instr", o_instr, 32'h00100293);
      check("bp_addr", 32'(o_addr), 0);
      step();
    end
    ir = 1'b1;
    step();
    check("bp_rel1_instr", o_instr, 32'h00200293);
    check("bp_rel1_addr", 32'(o_addr), 4);
    imm = 32'd3;
    step(); iv = 1'b0;
    check("bp_rel2_instr", o_instr, 32'h00300293);
    check("bp_rel2_addr", 32'(o_addr), 8);
    step();
    check("bp_drain", 32'(o_valid), 0);

    // Window fill
    clear_cycle(); ir = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      req(2'b00, 32'(k), 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0);
      step();
      check("fill_valid", 32'(o_valid), 1);
      check("fill_instr", o_instr, (32'(k) << 20) | 32'h293);
      check("fill_addr", 32'(o_addr), 32'((k - 1) * 4));
    end
    imm = 32'd5;
    step();
    check("full_flag", 32'(o_full), 1);
    check("full_valid", 32'(o_valid), 0);
    check("full_addr", 32'(o_addr), 32'hC);
    check("full_ready", 32'(o_ready), 0);
    imm = 32'd6;
    step();
    check("full_hold", 32'(o_full), 1);
    check("full_hold_valid", 32'(o_valid), 0);
    clr = 1'b1;
    step(); clr = 1'b0; iv = 1'b0;
    check("clr_addr", 32'(o_addr), 0);
    check("clr_full", 32'(o_full), 0);
    check("clr_valid", 32'(o_valid), 0);
    check("clr_ready", 32'(o_ready), 1);

    // Clear overrides output handshake and rejected request
    ir = 1'b0;
    req(2'b00, 32'd7, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0);
    step(); iv = 1'b0;
    check("pend_valid", 32'(o_valid), 1);
    ir = 1'b1; clr = 1'b1;
    step(); clr = 1'b0;
    check("clrhs_valid", 32'(o_valid), 0);
    check("clrhs_addr", 32'(o_addr), 0);
    req(2'b11, 32'd0, 7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0);
    clr = 1'b1;
    step(); clr = 1'b0; iv = 1'b0;
    check("clrrej_err", 32'(o_err), 0);
    check("clrrej_cnt", 32'(o_err_cnt), 32'(exp_cnt));
    req(2'b00, 32'd8, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0);
    step(); iv = 1'b0;
    check("after_clr_instr", o_instr, 32'h00800293);
    check("after_clr_addr", 32'(o_addr), 0);

    // Asynchronous reset with a word pending
    ir = 1'b0;
    req(2'b00, 32'd9, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0);
    step(); iv = 1'b0;
    check("pre_rst_valid", 32'(o_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(o_valid), 0);
    check("arst_instr", o_instr, 0);
    check("arst_addr", 32'(o_addr), 0);
    check("arst_cnt", 32'(o_err_cnt), 0);
    check("arst_ready", 32'(o_ready), 1);
    step();
    rst = 1'b0;

    // Error counter saturation
    ir = 1'b1;
    req(2'b11, 32'd0, 7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 260; i++) step();
    iv = 1'b0;
    check("sat_cnt", 32'(o_err_cnt), 32'd255);
    check("sat_addr", 32'(o_addr), 0);
    step();
    check("sat_hold", 32'(o_err_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
